// File: rtl/hnm_bank.sv
// SSID hit map: one bit per {row, col} SSID in a row-wide RAM, marked by a 2-stage
// read-modify-write, queried with a fixed 2-cycle latency, and wiped by a row-by-row sweep.
module hnm_bank #(
  parameter int unsigned ROW_BITS      = 7,
  parameter int unsigned COL_BITS      = 4,
  parameter int unsigned SETTLE_CYCLES = 2
) (
  input  logic                         clk,
  input  logic                         reset_n,
  input  logic                         clear,
  input  logic                         wr_valid,
  input  logic [ROW_BITS+COL_BITS-1:0] wr_ssid,
  output logic                         wr_ready,
  input  logic                         rd_valid,
  input  logic [ROW_BITS+COL_BITS-1:0] rd_ssid,
  output logic                         rd_ready,
  output logic                         rd_hit_valid,
  output logic                         rd_hit,
  output logic                         busy,
  output logic [ROW_BITS+COL_BITS:0]   set_count
);
  localparam int unsigned SSID_BITS    = ROW_BITS + COL_BITS;
  localparam int unsigned SETCNT_BITS  = SSID_BITS + 1;
  localparam int unsigned NUM_ROWS     = 1 << ROW_BITS;
  localparam int unsigned ROW_WIDTH    = 1 << COL_BITS;
  localparam int unsigned WAIT_BITS    = 4;
  localparam int unsigned DRAIN_CYCLES = 2;

  typedef enum logic [1:0] {CLEAR, SETTLE, RUN, DRAIN} stateT;

  stateT                 stateQ, stateNext;
  logic [ROW_BITS-1:0]   sweepRowQ, sweepRowNext;
  logic [WAIT_BITS-1:0]  waitCntQ, waitCntNext;

  logic [ROW_WIDTH-1:0]  mem [NUM_ROWS];
  logic [ROW_WIDTH-1:0]  wrRamQ, rdRamQ;

  logic                  s1Valid, fwdValid, r1Valid;
  logic [ROW_BITS-1:0]   s1Row, fwdRow, r1Row;
  logic [COL_BITS-1:0]   s1Col, r1Col;
  logic [ROW_WIDTH-1:0]  fwdData;

  logic                  wrAccept, rdAccept, newBit, enterClear;
  logic [ROW_BITS-1:0]   wrRow, rdRow;
  logic [COL_BITS-1:0]   wrCol, rdCol;
  logic [ROW_WIDTH-1:0]  wrRowData, rdRowData, mergedRow;

  assign wrAccept = wr_valid && wr_ready;
  assign rdAccept = rd_valid && rd_ready;
  assign wrRow    = wr_ssid[SSID_BITS-1:COL_BITS];
  assign wrCol    = wr_ssid[COL_BITS-1:0];
  assign rdRow    = rd_ssid[SSID_BITS-1:COL_BITS];
  assign rdCol    = rd_ssid[COL_BITS-1:0];

  // The RAM read misses the row committed on the same edge; fwd* holds that commit.
  assign wrRowData  = (fwdValid && fwdRow == s1Row) ? fwdData : wrRamQ;
  assign rdRowData  = (fwdValid && fwdRow == r1Row) ? fwdData : rdRamQ;
  assign mergedRow  = wrRowData | (ROW_WIDTH'(1) << s1Col);
  assign newBit     = s1Valid && !wrRowData[s1Col];
  assign enterClear = (stateQ == DRAIN) && (stateNext == CLEAR);

  // Map storage: one write port (sweep or RMW commit), two synchronous read ports.
  always_ff @(posedge clk) begin
    if (stateQ == CLEAR) begin
      mem[sweepRowQ] <= '0;
    end else if (s1Valid) begin
      mem[s1Row] <= mergedRow;
    end
    wrRamQ <= mem[wrRow];
    rdRamQ <= mem[rdRow];
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      stateQ    <= CLEAR;
      sweepRowQ <= '0;
      waitCntQ  <= '0;
    end else begin
      stateQ    <= stateNext;
      sweepRowQ <= sweepRowNext;
      waitCntQ  <= waitCntNext;
    end
  end

  always_comb begin
    stateNext    = stateQ;
    sweepRowNext = sweepRowQ;
    waitCntNext  = waitCntQ;
    case (stateQ)
      CLEAR: begin
        sweepRowNext = sweepRowQ + ROW_BITS'(1);
        if (sweepRowQ == ROW_BITS'(NUM_ROWS - 1)) begin
          stateNext   = SETTLE;
          waitCntNext = '0;
        end
      end
      SETTLE: begin
        waitCntNext = waitCntQ + WAIT_BITS'(1);
        if (waitCntQ == WAIT_BITS'(SETTLE_CYCLES - 1)) begin
          stateNext = RUN;
        end
      end
      RUN: begin
        if (clear) begin
          stateNext   = DRAIN;
          waitCntNext = '0;
        end
      end
      DRAIN: begin
        waitCntNext = waitCntQ + WAIT_BITS'(1);
        if (waitCntQ == WAIT_BITS'(DRAIN_CYCLES - 1)) begin
          stateNext    = CLEAR;
          sweepRowNext = '0;
        end
      end
      default: stateNext = CLEAR;
    endcase
  end

  // Pipeline stages, handshake outputs and the set counter.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      s1Valid      <= 1'b0;
      s1Row        <= '0;
      s1Col        <= '0;
      fwdValid     <= 1'b0;
      fwdRow       <= '0;
      fwdData      <= '0;
      r1Valid      <= 1'b0;
      r1Row        <= '0;
      r1Col        <= '0;
      rd_hit_valid <= 1'b0;
      rd_hit       <= 1'b0;
      wr_ready     <= 1'b0;
      rd_ready     <= 1'b0;
      busy         <= 1'b1;
      set_count    <= '0;
    end else begin
      s1Valid      <= wrAccept;
      s1Row        <= wrRow;
      s1Col        <= wrCol;
      fwdValid     <= s1Valid;
      fwdRow       <= s1Row;
      fwdData      <= mergedRow;
      r1Valid      <= rdAccept;
      r1Row        <= rdRow;
      r1Col        <= rdCol;
      rd_hit_valid <= r1Valid;
      rd_hit       <= r1Valid && rdRowData[r1Col];
      wr_ready     <= (stateNext == RUN);
      rd_ready     <= (stateNext == RUN);
      busy         <= (stateNext != RUN);
      if (enterClear) begin
        set_count <= '0;
      end else if (newBit) begin
        set_count <= set_count + SETCNT_BITS'(1);
      end
    end
  end
endmodule
